// File: rtl/intel8088_pkg.sv
// Shared types and defaults for the 8088 bus-sharing logic.
package intel8088_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_REQ,
        GRANT,
        TURN,
        RELEASE
    } hold_state_e;

    localparam int HOLD_N_DEFAULT   = 4;
    localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/hold_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    logic [W-1:0] j;

    // Walk from the farthest offset down so the nearest hit wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(ptr) + i) % N);
            if (req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/hold_arbiter.sv
// Shares the 8088 bus with N alternate masters via HOLD/HLDA,
// round-robin grants with a burst limit while others wait.
module hold_arbiter
    import intel8088_pkg::*;
#(
    parameter int N        = HOLD_N_DEFAULT,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GNT,
    output logic                 HOLD,
    input  logic                 HLDA,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 BUSY,
    output logic                 PROTO_ERR
);

    localparam int W  = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);

    hold_state_e  state;
    logic [W-1:0] ptr;
    logic [CW-1:0] cnt;

    logic         pick_valid;
    logic [W-1:0] pick_idx;
    logic [W-1:0] ptr_next;
    logic         owner_req;
    logic         rival;
    logic         at_limit;

    rr_pick #(.N(N)) u_pick (
        .req   (REQ),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        ptr_next  = (pick_idx == W'(N - 1)) ? '0 : pick_idx + 1'b1;
        owner_req = REQ[OWNER];
        rival     = |(REQ & ~(N'(1) << OWNER));
        at_limit  = cnt >= CW'(MAX_HOLD - 1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            HOLD      <= 1'b0;
            GNT       <= '0;
            OWNER     <= '0;
            BUSY      <= 1'b0;
            PROTO_ERR <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|REQ) begin
                        state <= HOLD_REQ;
                        HOLD  <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                HOLD_REQ: begin
                    if (HLDA && pick_valid) begin
                        state <= GRANT;
                        GNT   <= N'(1) << pick_idx;
                        OWNER <= pick_idx;
                        ptr   <= ptr_next;
                        cnt   <= '0;
                    end else if (HLDA) begin
                        state <= RELEASE;
                        HOLD  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!HLDA) begin
                        // CPU took the bus back under us.
                        state     <= RELEASE;
                        HOLD      <= 1'b0;
                        GNT       <= '0;
                        PROTO_ERR <= 1'b1;
                    end else if (!owner_req || (at_limit && rival)) begin
                        state <= TURN;
                        GNT   <= '0;
                    end else if (cnt != CW'(MAX_HOLD)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TURN: begin
                    if (!HLDA) begin
                        state     <= RELEASE;
                        HOLD      <= 1'b0;
                        PROTO_ERR <= 1'b1;
                    end else if (pick_valid) begin
                        state <= GRANT;
                        GNT   <= N'(1) << pick_idx;
                        OWNER <= pick_idx;
                        ptr   <= ptr_next;
                        cnt   <= '0;
                    end else begin
                        state <= RELEASE;
                        HOLD  <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!HLDA) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    HOLD  <= 1'b0;
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hold_arbiter.sv
// Self-checking bench for hold_arbiter: directed scenarios plus
// randomized traffic against a behavioural bus-ownership model.
module tb_hold_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 16;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [N-1:0] REQ;
    logic [N-1:0] GNT;
    logic         HOLD;
    logic         HLDA;
    logic [1:0]   OWNER;
    logic         BUSY;
    logic         PROTO_ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hold_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .GNT       (GNT),
        .HOLD      (HOLD),
        .HLDA      (HLDA),
        .OWNER     (OWNER),
        .BUSY      (BUSY),
        .PROTO_ERR (PROTO_ERR)
    );

    // Reference model: who owns the bus and what the CPU was asked.
    typedef enum int {P_IDLE, P_ASK, P_OWN, P_GAP, P_RET} phase_e;
    phase_e       ph;
    int           m_ptr, m_owner, m_ten;
    logic [N-1:0] m_gnt;
    logic         m_hold, m_busy, m_err;

    bit cpu_auto;
    int cpu_lat, cpu_cnt;

    function automatic void model_reset();
        ph      = P_IDLE;
        m_ptr   = 0;
        m_owner = 0;
        m_ten   = 0;
        m_gnt   = '0;
        m_hold  = 1'b0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
    endfunction

    // Winner is the requester with the smallest forward distance from ptr.
    function automatic int pick(logic [N-1:0] r, int p);
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - p + N) % N;
            if (r[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic void model_grant(logic [N-1:0] r);
        int w = pick(r, m_ptr);
        m_owner = w;
        m_gnt   = N'(1) << w;
        m_ptr   = (w + 1) % N;
        m_ten   = 0;
        ph      = P_OWN;
    endfunction

    function automatic void model_step(logic [N-1:0] r, logic h, logic rs);
        logic [N-1:0] others;
        if (rs) begin
            model_reset();
            return;
        end
        case (ph)
            P_IDLE: if (r != 0) begin ph = P_ASK; m_hold = 1'b1; end
            P_ASK: if (h) begin
                if (r != 0) model_grant(r);
                else begin ph = P_RET; m_hold = 1'b0; end
            end
            P_OWN, P_GAP: begin
                others = r & ~(N'(1) << m_owner);
                if (!h) begin
                    m_err = 1'b1; m_gnt = '0; m_hold = 1'b0; ph = P_RET;
                end else if (ph == P_GAP) begin
                    if (r != 0) model_grant(r);
                    else begin ph = P_RET; m_hold = 1'b0; end
                end else if (!r[m_owner] || (m_ten >= MAXH - 1 && others != 0)) begin
                    ph = P_GAP; m_gnt = '0;
                end else if (m_ten < MAXH) begin
                    m_ten++;
                end
            end
            P_RET: if (!h) ph = P_IDLE;
            default: ph = P_IDLE;
        endcase
        m_busy = (ph != P_IDLE);
    endfunction

    function automatic int oh_idx(logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic cpu_drive();
        if (cpu_auto) begin
            if (HOLD !== HLDA) begin
                cpu_cnt++;
                if (cpu_cnt > cpu_lat) begin
                    HLDA    = HOLD;
                    cpu_cnt = 0;
                end
            end else begin
                cpu_cnt = 0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] r;
        logic h, rs;
        r  = REQ;
        h  = HLDA;
        rs = RESET;
        @(posedge CLK);
        model_step(r, h, rs);
        #1;
        checks++;
        if (GNT !== m_gnt) begin
            errors++;
            $display("FAIL gnt @%0t: got %b expected %b", $time, GNT, m_gnt);
        end
        checks++;
        if (HOLD !== m_hold) begin
            errors++;
            $display("FAIL hold @%0t: got %b expected %b", $time, HOLD, m_hold);
        end
        checks++;
        if (OWNER !== 2'(m_owner)) begin
            errors++;
            $display("FAIL owner @%0t: got %0d expected %0d", $time, OWNER, m_owner);
        end
        checks++;
        if (BUSY !== m_busy) begin
            errors++;
            $display("FAIL busy @%0t: got %b expected %b", $time, BUSY, m_busy);
        end
        checks++;
        if (PROTO_ERR !== m_err) begin
            errors++;
            $display("FAIL proto_err @%0t: got %b expected %b", $time, PROTO_ERR, m_err);
        end
        cpu_drive();
    endtask

    task automatic apply_reset();
        RESET   = 1'b1;
        REQ     = '0;
        HLDA    = 1'b0;
        cpu_cnt = 0;
        step();
        step();
        RESET = 1'b0;
        step();
    endtask

    task automatic wait_grant(string name);
        int n = 0;
        while (GNT == '0 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (GNT == '0) begin
            errors++;
            $display("FAIL %s grant timeout: got gnt %b required nonzero", name, GNT);
        end
    endtask

    task automatic drain(string name);
        int n = 0;
        REQ      = '0;
        cpu_auto = 1'b1;
        while ((BUSY !== 1'b0 || HLDA !== 1'b0) && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s drain: got busy %b required 0", name, BUSY);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        REQ   = 4'b1111;
        HLDA  = 1'b0;
        repeat (4) begin
            step();
            checks++;
            if ({GNT, HOLD, OWNER, BUSY, PROTO_ERR} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %b/%b/%0d/%b/%b required all 0",
                         GNT, HOLD, OWNER, BUSY, PROTO_ERR);
            end
        end
        REQ   = '0;
        RESET = 1'b0;
        step();
    endtask

    task automatic test_single();
        apply_reset();
        cpu_auto = 1'b0;
        REQ = 4'b0100;
        step();
        checks++;
        if (HOLD !== 1'b1 || GNT !== '0) begin
            errors++;
            $display("FAIL single_hold_rise: got hold %b gnt %b required 1 0000", HOLD, GNT);
        end
        repeat (3) step();
        HLDA = 1'b1;
        step();
        checks++;
        if (GNT !== 4'b0100 || OWNER !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: got gnt %b owner %0d required 0100 2", GNT, OWNER);
        end
        repeat (2) step();
        REQ = '0;
        step();
        checks++;
        if (GNT !== '0 || HOLD !== 1'b1) begin
            errors++;
            $display("FAIL single_turn: got gnt %b hold %b required 0000 1", GNT, HOLD);
        end
        step();
        checks++;
        if (HOLD !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL single_release: got hold %b busy %b required 0 1", HOLD, BUSY);
        end
        HLDA = 1'b0;
        step();
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy %b required 0", BUSY);
        end
    endtask

    task automatic test_round_robin();
        int owners[$];
        int lens[$];
        int gaps[$];
        int exp_own[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] prev = '0;
        int cur = 0, gap = 0, n = 0;
        bit hold_drop = 1'b0;
        apply_reset();
        cpu_auto = 1'b1;
        cpu_lat  = 1;
        REQ      = 4'b1111;
        while (lens.size() < 5 && n < 250) begin
            step();
            n++;
            if (GNT != '0) begin
                if (GNT != prev) begin
                    if (prev != '0) lens.push_back(cur);
                    else if (owners.size() > 0) gaps.push_back(gap);
                    owners.push_back(oh_idx(GNT));
                    cur = 1;
                end else begin
                    cur++;
                end
            end else if (prev != '0) begin
                lens.push_back(cur);
                gap = 1;
            end else begin
                gap++;
            end
            if (owners.size() > 0 && HOLD !== 1'b1) hold_drop = 1'b1;
            prev = GNT;
        end
        checks++;
        if (lens.size() < 5 || gaps.size() < 4) begin
            errors++;
            $display("FAIL rr_progress: got %0d tenures required 5", lens.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (owners[i] != exp_own[i] || lens[i] != MAXH) begin
                    errors++;
                    $display("FAIL rr_tenure%0d: got owner %0d len %0d required %0d %0d",
                             i, owners[i], lens[i], exp_own[i], MAXH);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gaps[i] != 1) begin
                    errors++;
                    $display("FAIL rr_gap%0d: got %0d required 1", i, gaps[i]);
                end
            end
        end
        checks++;
        if (hold_drop) begin
            errors++;
            $display("FAIL rr_hold: got hold drop 1 required 0");
        end
        drain("rr");
    endtask

    task automatic test_no_competitor();
        int held = 0;
        cpu_auto = 1'b1;
        cpu_lat  = 2;
        REQ      = 4'b0001;
        wait_grant("solo");
        for (int i = 0; i < 100; i++) begin
            if (GNT === 4'b0001) held++;
            step();
        end
        checks++;
        if (held != 100) begin
            errors++;
            $display("FAIL solo_hold: got %0d cycles required 100", held);
        end
        drain("solo");
    endtask

    task automatic test_proto_err();
        cpu_auto = 1'b1;
        cpu_lat  = 0;
        REQ      = 4'b0010;
        wait_grant("perr");
        step();
        cpu_auto = 1'b0;
        HLDA     = 1'b0;
        step();
        checks++;
        if (PROTO_ERR !== 1'b1 || GNT !== '0) begin
            errors++;
            $display("FAIL perr_set: got err %b gnt %b required 1 0000", PROTO_ERR, GNT);
        end
        REQ = '0;
        repeat (5) step();
        checks++;
        if (PROTO_ERR !== 1'b1 || HOLD !== 1'b0) begin
            errors++;
            $display("FAIL perr_sticky: got err %b hold %b required 1 0", PROTO_ERR, HOLD);
        end
        apply_reset();
        checks++;
        if (PROTO_ERR !== 1'b0) begin
            errors++;
            $display("FAIL perr_clear: got %b required 0", PROTO_ERR);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        cpu_auto = 1'b1;
        cpu_lat  = 2;
        REQ      = 4'b0100;
        wait_grant("areset");
        repeat (3) step();
        cpu_auto = 1'b0;
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if ({GNT, HOLD, BUSY} !== '0) begin
            errors++;
            $display("FAIL areset_drop: got gnt %b hold %b busy %b required 0", GNT, HOLD, BUSY);
        end
        model_reset();
        HLDA    = 1'b0;
        cpu_cnt = 0;
        repeat (2) step();
        RESET    = 1'b0;
        REQ      = 4'b1111;
        cpu_auto = 1'b1;
        wait_grant("areset_regrant");
        checks++;
        if (GNT !== 4'b0001 || OWNER !== 2'd0) begin
            errors++;
            $display("FAIL areset_ptr: got gnt %b owner %0d required 0001 0", GNT, OWNER);
        end
        drain("areset");
    endtask

    task automatic test_random();
        apply_reset();
        cpu_auto = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 11) == 0) REQ = 4'($urandom());
            if ($urandom_range(0, 15) == 0) REQ[$urandom_range(0, 3)] ^= 1'b1;
            if (cpu_cnt == 0) cpu_lat = $urandom_range(0, 3);
            step();
        end
        drain("random");
    endtask

    initial begin
        RESET    = 1'b1;
        REQ      = '0;
        HLDA     = 1'b0;
        cpu_auto = 1'b0;
        cpu_lat  = 0;
        cpu_cnt  = 0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_no_competitor();
        test_proto_err();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
